// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide unit, one bit per cycle, with a
//             single-cycle register-file write on completion.
//             Optional macro MULDIV_EARLY_OUT_EN: special cases skip CALC.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [XLEN-1:0]      rs1_val,
    input  logic [XLEN-1:0]      rs2_val,
    input  logic [REGADDR_W-1:0] rd_in,
    output logic                 busy,
    output logic                 done,
    output logic [XLEN-1:0]      result,
    output logic [REGADDR_W-1:0] rd_out,
    output logic                 wer
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [REGADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]      hi_q, hi_d;
    logic [XLEN-1:0]      lo_q, lo_d;
    logic [XLEN-1:0]      mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic                 negr_q, negr_d;
    logic                 spec_q, spec_d;
    logic [XLEN-1:0]      specv_q, specv_d;
    logic [XLEN-1:0]      result_q, result_d;

    // ------------------------------------------------------------------
    // Operand decode at issue
    // ------------------------------------------------------------------
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div0, w_ovf, w_mul0, w_special, w_early;
    logic [XLEN-1:0] w_spec_val;

    assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~rs1_val + 1'b1) : rs1_val;
    assign w_b_mag    = w_b_neg ? (~rs2_val + 1'b1) : rs2_val;

    assign w_div0    = op[2] && (rs2_val == '0);
    assign w_ovf     = op[2] && !op[0] && (rs1_val == INT_MIN) && (rs2_val == '1);
    assign w_mul0    = !op[2] && ((rs1_val == '0) || (rs2_val == '0));
    assign w_special = w_div0 || w_ovf || w_mul0;

    // Divide-by-zero must win over overflow: b == 0 can never be -1 anyway.
    always_comb begin
        w_spec_val = '0;
        if (w_div0)
            w_spec_val = op[1] ? rs1_val : '1;
        else if (w_ovf)
            w_spec_val = op[1] ? '0 : INT_MIN;
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = start && w_special;
`else
    assign w_early = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath: hi/lo hold the product, or remainder/quotient
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_sum, w_trial, w_diff;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    assign w_sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign w_trial    = {hi_q, lo_q[XLEN-1]};
    assign w_diff     = w_trial - {1'b0, mcand_q};
    assign w_prod     = {hi_q, lo_q};
    assign w_prod_fix = neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo      = neg_q ? (~lo_q + 1'b1) : lo_q;
    assign w_rem      = negr_q ? (~hi_q + 1'b1) : hi_q;

    always_comb begin
        if (spec_q)
            w_final = specv_q;
        else if (op_q[2])
            w_final = op_q[1] ? w_rem : w_quo;
        else if (op_q == OP_MUL)
            w_final = w_prod_fix[XLEN-1:0];
        else
            w_final = w_prod_fix[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = w_early ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        wer    = (state_q == S_DONE) && (rd_q != '0);
        result = result_q;
        rd_out = rd_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        spec_d   = spec_q;
        specv_d  = specv_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    rd_d    = rd_in;
                    cnt_d   = '0;
                    hi_d    = '0;
                    neg_d   = w_a_neg ^ w_b_neg;
                    negr_d  = w_a_neg;
                    spec_d  = w_special;
                    specv_d = w_spec_val;
                    if (op[2]) begin
                        mcand_d = w_b_mag;
                        lo_d    = w_a_mag;
                    end else begin
                        mcand_d = w_a_mag;
                        lo_d    = w_b_mag;
                    end
                    if (w_early)
                        result_d = w_spec_val;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    result_d = w_final;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_q[2]) begin
                        // Restoring division: keep the trial only when it did not go negative.
                        if (!w_diff[XLEN]) begin
                            hi_d = w_diff[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = w_trial[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = w_sum[XLEN:1];
                        lo_d = {w_sum[0], lo_q[XLEN-1:1]};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            spec_q   <= 1'b0;
            specv_q  <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            spec_q   <= spec_d;
            specv_q  <= specv_d;
            result_q <= result_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit (directed table + random).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [RW-1:0]   rd_in;
    logic            busy, done, wer;
    logic [XLEN-1:0] result;
    logic [RW-1:0]   rd_out;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.XLEN(XLEN), .REGADDR_W(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .wer     (wer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model from the architectural definition of each opcode.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint   sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = a;
        ib = b;
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit sp;
        sp = o[2] ? ((b == 0) || (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                  : ((a == 0) || (b == 0));
`ifdef MULDIV_EARLY_OUT_EN
        return sp ? 0 : XLEN + 1;
`else
        if (sp) return XLEN + 1;
        return XLEN + 1;
`endif
    endfunction

    // Issue one op and check latency, result, rd_out, wer and single-cycle done.
    // If pulse is set, a conflicting start is driven mid-operation.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit pulse);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (pulse && cyc == 5) begin
                start = 1'b1; op = ~o; rs1_val = ~a; rs2_val = b + 32'd9; rd_in = ~rd;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " latency"}, cyc, exp_latency(o, a, b));
        chk({tag, " result"}, result, exp);
        chk({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        chk({tag, " wer"}, {31'd0, wer}, {31'd0, (rd != 0)});
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, {30'd0, done, wer}, 32'd0);
        chk({tag, " busy_clear"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t tbl[15];

    initial begin
        int stray;
        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
        tbl[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2};
        tbl[8]  = '{3'd5, 32'd100,        32'd0,         5'd13, 32'hFFFF_FFFF};
        tbl[9]  = '{3'd7, 32'd100,        32'd0,         5'd14, 32'd100};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0};
        tbl[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         5'd17, 32'hFFFF_FFFF};
        tbl[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd18, 32'hFFFF_FFF9};
        tbl[14] = '{3'd1, 32'd0,          32'h1234_5678, 5'd19, 32'd0};

        rst_n = 1'b0; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {busy, done, wer, rd_out, result[24:0]}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, 1'b0);

        // rd=0 with an ignored start pulse while busy
        do_op("mul_rd0_pulse", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 1'b1);

        // Reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd7; rd_in = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", {28'd0, busy, done, wer, 1'b0}, 32'd0);
        chk("midreset result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || wer || busy) stray++;
        end
        chk("no stale write", stray, 32'd0);
        do_op("divu_after_reset", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            logic [4:0]  rrd;
            int sel;
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rrd = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) ra = 32'd0;
            else if (sel == 3) rb = 32'($urandom_range(1, 15));
            do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rrd, model(ro, ra, rb), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
